x_top_uart_tx: RTL and testbench

UART transmitter, the partner of the UART receiver on the same serial link. It accepts bytes on a valid/ready handshake into a small FIFO and serialises each byte as 8N1: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high). It sits between the CPU-side peripheral register interface and the top-level TX pin.

---
 rtl/x_uart_pkg.sv | 31 +++
 rtl/x_top_uart_tx_fifo.sv | 56 +++++
 rtl/x_top_uart_tx.sv | 136 +++++++++++++
 tb/tb_x_top_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the FSM state encoding, data-bit count and bit-period helper.
package x_uart_pkg;

   localparam int unsigned c_uart_data_bits = 8;

   typedef enum logic [3:0] {
      IDLE,
      START,
      D0,
      D1,
      D2,
      D3,
      D4,
      D5,
      D6,
      D7,
      STOP
   } sm_uart_tx_t;

   // Clock cycles per bit, never fewer than two.
   function automatic int unsigned uart_bit_period(
      input int unsigned clk_hz,
      input int unsigned baud
   );
      int unsigned p;
      p = clk_hz / baud;
      return (p < 2) ? 2 : p;
   endfunction

endpackage

// File: rtl/x_top_uart_tx_fifo.sv
// Byte FIFO between the handshake side and the serialiser.
// Ports: i_clk, i_rst (async, high), push/wdata in, pop/rdata out,
// full/empty status. Pointers carry one extra wrap bit.
module x_top_uart_tx_fifo #(
   parameter int unsigned p_depth = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned c_aw = $clog2(p_depth);

   logic [c_aw:0] wr_ptr_q;
   logic [c_aw:0] wr_ptr_d;
   logic [c_aw:0] rd_ptr_q;
   logic [c_aw:0] rd_ptr_d;
   logic [7:0]    mem_q [p_depth];
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                  (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
   assign rdata = mem_q[rd_ptr_q[c_aw-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[c_aw-1:0]] <= wdata;
   end

endmodule

// File: rtl/x_top_uart_tx.sv
// 8N1 UART transmitter with a small input FIFO.
// Ports: i_clk, i_rst (async, high), i_valid/o_ready/i_data byte
// handshake, o_tx registered serial line, o_busy activity flag.
module x_top_uart_tx
   import x_uart_pkg::*;
#(
   parameter int unsigned p_clk_hz = 1000000,
   parameter int unsigned p_baud   = 9600,
   parameter int unsigned p_depth  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int unsigned c_bit_period = uart_bit_period(p_clk_hz, p_baud);
   localparam int unsigned c_tw = $clog2(c_bit_period);
   localparam logic [c_tw-1:0] c_last = c_tw'(c_bit_period - 1);

   sm_uart_tx_t state_q;
   sm_uart_tx_t state_d;
   logic [c_tw-1:0] timer_q;
   logic [c_tw-1:0] timer_d;
   logic [c_uart_data_bits-1:0] sh_q;
   logic [c_uart_data_bits-1:0] sh_d;
   logic tx_q;
   logic tx_d;
   logic busy_q;
   logic busy_d;

   logic       bit_tick;
   logic       fifo_push;
   logic       fifo_pop;
   logic [7:0] fifo_rdata;
   logic       fifo_full;
   logic       fifo_empty;

   assign fifo_push = i_valid & ~fifo_full;
   assign o_ready   = ~fifo_full;
   assign o_tx      = tx_q;
   assign o_busy    = busy_q;
   assign bit_tick  = (timer_q == c_last);

   x_top_uart_tx_fifo #(
      .p_depth(p_depth)
   ) u_fifo (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .push (fifo_push),
      .pop  (fifo_pop),
      .wdata(i_data),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sh_d     = fifo_rdata;
               state_d  = START;
            end
         end
         START: begin
            if (bit_tick) state_d = D0;
         end
         D0, D1, D2, D3, D4, D5, D6, D7: begin
            if (bit_tick) begin
               sh_d = sh_q >> 1;
               if (state_q == D7) state_d = STOP;
               else state_d = sm_uart_tx_t'(state_q + 4'd1);
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  sh_d     = fifo_rdata;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (state_q == IDLE || bit_tick) timer_d = '0;
   end

   // Line level follows the next state so the flop leads the state
   // by nothing: the start bit appears on the same edge as START.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START: tx_d = 1'b0;
         D0, D1, D2, D3, D4, D5, D6, D7: tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // Entering or staying in IDLE implies no pop and an empty FIFO
   // unless a byte lands on this same edge.
   always_comb begin
      busy_d = (state_d != IDLE) | fifo_push;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_x_top_uart_tx.sv
// Self-checking bench for x_top_uart_tx.
// Timeline model of frames plus a loop-back receiver.
module tb_x_top_uart_tx;

   localparam int BP    = 1000000 / 100000;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * BP;

   logic       clk;
   logic       i_rst;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_data;
   logic       o_tx;
   logic       o_busy;

   int n_chk;
   int n_pass;
   int n_fail;
   int cyc;
   int base;
   logic last_acc;

   int         push_c[$];
   int         start_c[$];
   logic [7:0] dat_q[$];

   logic       rx_busy;
   int         rx_cnt;
   logic [7:0] rx_sh;
   int         rx_idx;

   x_top_uart_tx #(
      .p_clk_hz(1000000),
      .p_baud  (100000),
      .p_depth (DEPTH)
   ) dut (
      .i_clk  (clk),
      .i_rst  (i_rst),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_data (i_data),
      .o_tx   (o_tx),
      .o_busy (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Bytes waiting in the FIFO after edge c.
   function automatic int occ(input int c);
      int n;
      n = 0;
      for (int k = base; k < start_c.size(); k++)
         if (push_c[k] <= c && start_c[k] > c) n++;
      return n;
   endfunction

   function automatic logic exp_tx(input int c);
      int b;
      for (int k = base; k < start_c.size(); k++) begin
         if (c >= start_c[k] && c < start_c[k] + FRAME) begin
            b = (c - start_c[k]) / BP;
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return dat_q[k][b-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int c);
      for (int k = base; k < start_c.size(); k++)
         if (push_c[k] <= c && c < start_c[k] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   task automatic rx_step(input logic v);
      int b;
      if (!rx_busy) begin
         if (v === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % BP == BP / 2) begin
            b = rx_cnt / BP;
            if (b == 0) begin
               chk("rx_start", {31'd0, v}, 32'd0);
            end else if (b <= 8) begin
               rx_sh[b-1] = v;
            end else begin
               chk("rx_stop", {31'd0, v}, 32'd1);
               if (rx_idx < dat_q.size())
                  chk("rx_byte", {24'd0, rx_sh}, {24'd0, dat_q[rx_idx]});
               else
                  chk("rx_extra", rx_idx, dat_q.size() - 1);
               rx_idx++;
               rx_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      logic acc;
      int   s;
      acc = i_valid && (occ(cyc) < DEPTH);
      @(posedge clk);
      cyc++;
      if (acc) begin
         s = cyc + 1;
         if (start_c.size() > base && start_c[$] + FRAME > s)
            s = start_c[$] + FRAME;
         push_c.push_back(cyc);
         start_c.push_back(s);
         dat_q.push_back(i_data);
      end
      last_acc = acc;
      @(negedge clk);
      chk("tx", {31'd0, o_tx}, {31'd0, exp_tx(cyc)});
      chk("busy", {31'd0, o_busy}, {31'd0, exp_busy(cyc)});
      chk("ready", {31'd0, o_ready}, {31'd0, occ(cyc) < DEPTH});
      rx_step(o_tx);
   endtask

   task automatic send(input logic [7:0] d);
      int i;
      i_valid = 1'b1;
      i_data  = d;
      i = 0;
      do begin
         tick();
         i++;
      end while (!last_acc && i < 2000);
      if (!last_acc) chk("send_timeout", i, 0);
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_tx", {31'd0, o_tx}, 32'd1);
      chk("arst_busy", {31'd0, o_busy}, 32'd0);
      chk("arst_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      i_rst   = 1'b0;
      base    = dat_q.size();
      rx_idx  = base;
      rx_busy = 1'b0;
   endtask

   initial begin
      int k;
      clk      = 1'b0;
      i_rst    = 1'b1;
      i_valid  = 1'b0;
      i_data   = 8'h00;
      n_chk    = 0;
      n_pass   = 0;
      n_fail   = 0;
      cyc      = 0;
      base     = 0;
      last_acc = 1'b0;
      rx_busy  = 1'b0;
      rx_cnt   = 0;
      rx_sh    = 8'h00;
      rx_idx   = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", {31'd0, o_tx}, 32'd1);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      i_rst = 1'b0;
      idle(200);

      send(8'hA5);
      idle(120);

      send(8'h00);
      send(8'hFF);
      send(8'h3C);
      send(8'h81);
      send(8'h55);
      idle(600);

      for (int i = 0; i < 5; i++) send(8'($urandom));
      i_data = 8'h11;
      repeat (5) tick();
      send(8'h22);
      idle(700);

      send(8'h0F);
      k = start_c.size() - 1;
      send(8'($urandom));
      send(8'($urandom));
      i_valid = 1'b0;
      while (cyc < start_c[k] + 4 * BP + 5) tick();
      do_reset();
      idle(300);

      send(8'h5A);
      k = start_c.size() - 1;
      i_valid = 1'b0;
      while (cyc < start_c[k] + 9 * BP + 2) tick();
      send(8'hC3);
      idle(250);

      for (int i = 0; i < 3000; i++) begin
         i_valid = ($urandom_range(0, 3) == 0);
         i_data  = 8'($urandom);
         tick();
      end
      idle(800);
      chk("rx_count", rx_idx, dat_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
